axis_upsize_md: RTL and testbench
=================================

# axis_upsize_md

Parametrised AXI-stream width up-converter: packs RATIO consecutive IDSIZE-bit beats from an upstream `axi_stream_inf` slaver port into one ODSIZE = IDSIZE*RATIO-bit beat on a master port. It also holds the last emitted word on a plain `odata` bus. Generalises the fixed-width sdl/hdl stream endpoints with configurable width, lane order and tlast-flush with zero padding. It sits between a narrow producer and a wide consumer in the main datapath.

## Interface
- IDSIZE, 8: input beat width (bits).
- RATIO, 4: input beats per output beat, >= 2.
- MSB_FIRST, 0: 0 = first accepted beat lands in bits [IDSIZE-1:0]; 1 = first beat lands in the top lane.
- ODSIZE, IDSIZE*RATIO: derived output width; do not override.
- LW, $clog2(RATIO+1): width of the lane-count sideband.

Ports:
- clock  input  1  block clock; both interfaces' aclk are driven from it.
- rst_n  input  1  asynchronous, active-low reset.
- in_inf  axi_stream_inf.slaver  DSIZE=IDSIZE  narrow input stream; uses tdata, tvalid, tready, tlast.
- out_inf  axi_stream_inf.master  DSIZE=ODSIZE  wide output stream; drives tdata, tvalid, tlast, tkeep=all ones, tuser=0.
- olanes  output  LW  number of valid input lanes in the current out_inf beat (1..RATIO); meaningful while out_inf.tvalid.
- odata  output  ODSIZE  copy of the last out_inf word that completed a handshake.
- pkt_cnt  output  16  completed output packets (see Configuration).

## Operation
- State: lane index `idx` (0..RATIO-1), accumulator `acc` (ODSIZE), output register (tdata/tlast/olanes/tvalid).
- Stall rule: in_inf.tready = !out_inf.tvalid || out_inf.tready. Combinational from out_inf.tready; no other dependency.
- Input accept (tvalid && tready): the beat is written into lane `idx` of `acc`. With MSB_FIRST=1, lane RATIO-1-idx is used instead.
- Completion: an accepted beat with idx==RATIO-1 or tlast=1 completes the word. On completion:
  - the output register loads `acc` with the new lane merged, and all lanes above the written lane are forced to zero (the equivalent lanes when MSB_FIRST=1);
  - out tlast = in tlast; olanes = idx+1; tvalid=1;
  - `acc` is cleared and idx returns to 0.
- Otherwise idx increments.
- Output handshake (tvalid && tready): tvalid drops unless a new completion occurs in the same cycle, in which case the register reloads and tvalid stays 1. odata loads the departing word.
- tlast on the first lane gives a single-lane word: olanes=1, upper lanes zero.
- Reset (asynchronous, any time): idx=0, acc=0, out tvalid=0, tdata=0, tlast=0, olanes=0, odata=0, pkt_cnt=0. A partially accumulated word is discarded. No output beat is emitted after reset release until a new completion.

## Timing
- Latency: out_inf.tvalid rises on the clock edge that accepts the completing input beat, i.e. one cycle after that beat is presented.
- Throughput with out_inf.tready held at 1: one output beat per RATIO accepted input beats. in_inf.tready stays 1.
- Back-pressure: while out_inf.tvalid=1 and tready=0, in_inf.tready=0. tdata, tlast and olanes stay stable until the handshake.
- Simultaneous output handshake and completing input in the same cycle: both take effect, with no bubble.
- odata updates on the edge of the out_inf handshake and holds otherwise.

## Configuration
- AXIS_UPSIZE_PKT_CNT_EN defined: pkt_cnt is a 16-bit counter, incremented on each out_inf handshake with tlast=1, wrapping 0xFFFF->0x0000, reset to 0.
- Not defined: pkt_cnt is tied to 16'h0000 and no counter flops are built.

## Test plan
- IDSIZE=8, RATIO=4, MSB_FIRST=0, out ready=1; input 0x11,0x22,0x33,0x44 (tlast on 0x44) -> one beat tdata=0x44332211, tlast=1, olanes=4, one cycle after 0x44 accepted; odata=0x44332211 after the handshake.
- Same, MSB_FIRST=1 -> tdata=0x11223344.
- Input 0xAA,0xBB with tlast on 0xBB -> tdata=0x0000BBAA, olanes=2, tlast=1; next packet starts at lane 0.
- Hold out ready=0 after the first completion, keep input valid -> in tready=0 and tdata stable for 10 cycles. Release ready -> stream continues with no lost or duplicated beat; 8 input beats produce exactly 2 outputs.
- Assert rst_n low after 2 of 4 beats, then release and send 0x01..0x04 -> only tdata=0x04030201 is emitted; every output is zero during reset.
- With AXIS_UPSIZE_PKT_CNT_EN defined, send 3 packets -> pkt_cnt=3. Preload 0xFFFF by sending 65536 packets -> pkt_cnt wraps to 0. Without the macro, pkt_cnt=0 throughout.

Source files
------------

// File: rtl/axis_upsize_md_if.sv
// AXI-stream interface shared by the narrow and wide sides of axis_upsize_md.
// Both sides run on the block clock through aclk.
interface axi_stream_inf #(
  parameter int DSIZE = 8
) (
  input logic aclk
);
  localparam int KSIZE = (DSIZE + 7) / 8;

  logic [DSIZE-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;
  logic [KSIZE-1:0] tkeep;
  logic             tuser;

  modport master (
    input  aclk,
    input  tready,
    output tdata, tvalid, tlast, tkeep, tuser
  );

  modport slaver (
    input  aclk,
    input  tdata, tvalid, tlast, tkeep, tuser,
    output tready
  );
endinterface

// File: rtl/axis_upsize_md.sv
// axis_upsize_md: packs RATIO narrow beats into one wide AXI-stream beat.
// tlast flushes a partial word with the unwritten lanes zeroed.
// Optional feature macro: AXIS_UPSIZE_PKT_CNT_EN (16-bit packet counter on
// pkt_cnt; when undefined pkt_cnt is tied to zero).

// One lane of the accumulator. POS is the lane's position in arrival order,
// so MSB_FIRST only changes which physical lane each instance sits on.
module axis_upsize_md_lane #(
  parameter int W   = 8,
  parameter int IW  = 2,
  parameter int POS = 0
) (
  input  logic [IW-1:0] idx_i,
  input  logic          wr_i,
  input  logic [W-1:0]  din_i,
  input  logic [W-1:0]  acc_i,
  output logic [W-1:0]  acc_nxt_o,
  output logic [W-1:0]  word_o
);
  logic hit;
  logic above;

  assign hit   = (idx_i == IW'(POS));
  // Lanes later than the one being written are padding in a flushed word.
  assign above = (idx_i < IW'(POS));

  // Merge the incoming beat into this lane when it is the write target.
  always_comb begin
    acc_nxt_o = acc_i;
    if (wr_i && hit) acc_nxt_o = din_i;
  end

  assign word_o = above ? '0 : acc_nxt_o;
endmodule

module axis_upsize_md #(
  parameter int IDSIZE    = 8,
  parameter int RATIO     = 4,
  parameter bit MSB_FIRST = 1'b0,
  parameter int ODSIZE    = IDSIZE * RATIO,
  parameter int LW        = $clog2(RATIO + 1)
) (
  input  logic              clock,
  input  logic              rst_n,
  axi_stream_inf.slaver     in_inf,
  axi_stream_inf.master     out_inf,
  output logic [LW-1:0]     olanes,
  output logic [ODSIZE-1:0] odata,
  output logic [15:0]       pkt_cnt
);
  localparam int IW = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [IW-1:0]                 idx_q, idx_d;
  logic [RATIO-1:0][IDSIZE-1:0]  acc_q, acc_d, word_d;
  logic [ODSIZE-1:0]             tdata_q, odata_q;
  logic                          tlast_q, vld_q, vld_d;
  logic [LW-1:0]                 olanes_q;

  logic in_rdy, accept, last_lane, complete, out_hs;

  // The input only stalls when a finished word is still waiting downstream.
  assign in_rdy    = !vld_q || out_inf.tready;
  assign accept    = in_inf.tvalid && in_rdy;
  assign last_lane = (idx_q == IW'(RATIO - 1));
  assign complete  = accept && (last_lane || in_inf.tlast);
  assign out_hs    = vld_q && out_inf.tready;

  // Per-lane merge and padding; physical lane j holds arrival position POS.
  for (genvar j = 0; j < RATIO; j++) begin : g_lane
    localparam int POS = MSB_FIRST ? (RATIO - 1 - j) : j;
    axis_upsize_md_lane #(
      .W   (IDSIZE),
      .IW  (IW),
      .POS (POS)
    ) u_lane (
      .idx_i     (idx_q),
      .wr_i      (accept),
      .din_i     (in_inf.tdata),
      .acc_i     (acc_q[j]),
      .acc_nxt_o (acc_d[j]),
      .word_o    (word_d[j])
    );
  end

  // Lane index and output-valid next state.
  always_comb begin
    idx_d = idx_q;
    vld_d = vld_q;
    if (complete)    idx_d = '0;
    else if (accept) idx_d = idx_q + IW'(1);
    if (complete)    vld_d = 1'b1;
    else if (out_hs) vld_d = 1'b0;
  end

  // Accumulator, output register and departing-word copy.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      acc_q    <= '0;
      vld_q    <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      olanes_q <= '0;
      odata_q  <= '0;
    end else begin
      idx_q <= idx_d;
      vld_q <= vld_d;
      if (complete) begin
        acc_q    <= '0;
        tdata_q  <= word_d;
        tlast_q  <= in_inf.tlast;
        olanes_q <= LW'(idx_q) + LW'(1);
      end else if (accept) begin
        acc_q <= acc_d;
      end
      if (out_hs) odata_q <= tdata_q;
    end
  end

`ifdef AXIS_UPSIZE_PKT_CNT_EN
  logic [15:0] pkt_cnt_q;

  // Count packets as their last wide beat leaves; wraps naturally at 16 bits.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                 pkt_cnt_q <= '0;
    else if (out_hs && tlast_q) pkt_cnt_q <= pkt_cnt_q + 16'd1;
  end

  assign pkt_cnt = pkt_cnt_q;
`else
  assign pkt_cnt = 16'h0000;
`endif

  assign in_inf.tready  = in_rdy;
  assign out_inf.tdata  = tdata_q;
  assign out_inf.tvalid = vld_q;
  assign out_inf.tlast  = tlast_q;
  assign out_inf.tkeep  = '1;
  assign out_inf.tuser  = 1'b0;
  assign olanes         = olanes_q;
  assign odata          = odata_q;
endmodule

// File: tb/tb_axis_upsize_md.sv
// Directed bench for axis_upsize_md: LSB-first and MSB-first instances fed
// with the same narrow stream.
module tb_axis_upsize_md;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  axi_stream_inf #(.DSIZE(8))  in0  (.aclk(clock));
  axi_stream_inf #(.DSIZE(32)) out0 (.aclk(clock));
  axi_stream_inf #(.DSIZE(8))  in1  (.aclk(clock));
  axi_stream_inf #(.DSIZE(32)) out1 (.aclk(clock));

  logic [2:0]  olanes0, olanes1;
  logic [31:0] odata0, odata1;
  logic [15:0] pkt0, pkt1;

  assign in1.tdata   = in0.tdata;
  assign in1.tvalid  = in0.tvalid;
  assign in1.tlast   = in0.tlast;
  assign in1.tkeep   = in0.tkeep;
  assign in1.tuser   = in0.tuser;
  assign out1.tready = out0.tready;

  axis_upsize_md #(.IDSIZE(8), .RATIO(4), .MSB_FIRST(1'b0)) u_dut0 (
    .clock(clock), .rst_n(rst_n), .in_inf(in0), .out_inf(out0),
    .olanes(olanes0), .odata(odata0), .pkt_cnt(pkt0)
  );

  axis_upsize_md #(.IDSIZE(8), .RATIO(4), .MSB_FIRST(1'b1)) u_dut1 (
    .clock(clock), .rst_n(rst_n), .in_inf(in1), .out_inf(out1),
    .olanes(olanes1), .odata(odata1), .pkt_cnt(pkt1)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Record every wide beat that will complete a handshake on the next edge.
  always @(negedge clock) begin
    #2;
    if (out0.tvalid && out0.tready) q.push_back(out0.tdata);
  end

  // Present one narrow beat (called at a falling edge), wait for acceptance,
  // return at the falling edge after the accepting rising edge.
  task automatic put(input logic [7:0] d, input logic l);
    int n;
    in0.tdata  = d;
    in0.tlast  = l;
    in0.tvalid = 1'b1;
    n = 0;
    #1;
    while (!in0.tready && n < 50) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (n >= 50) chk("put_timeout", 64'd0, 64'd1);
    @(posedge clock);
    @(negedge clock);
    in0.tvalid = 1'b0;
    in0.tlast  = 1'b0;
  endtask

  initial begin
    in0.tdata   = '0;
    in0.tvalid  = 1'b0;
    in0.tlast   = 1'b0;
    in0.tkeep   = '1;
    in0.tuser   = 1'b0;
    out0.tready = 1'b1;

    // reset state
    #12;
    chk("rst_tvalid", out0.tvalid, 0);
    chk("rst_tdata",  out0.tdata,  0);
    chk("rst_olanes", olanes0,     0);
    chk("rst_odata",  odata0,      0);
    @(negedge clock);
    rst_n = 1'b1;

    // full packet, both lane orders
    put(8'h11, 0); put(8'h22, 0); put(8'h33, 0);
    chk("pre_tvalid", out0.tvalid, 0);
    chk("in_ready",   in0.tready,  1);
    put(8'h44, 1);
    chk("p1_tvalid", out0.tvalid, 1);
    chk("p1_tdata",  out0.tdata,  32'h44332211);
    chk("p1_tlast",  out0.tlast,  1);
    chk("p1_olanes", olanes0,     4);
    chk("p1_keep",   out0.tkeep,  4'hF);
    chk("p1_msb",    out1.tdata,  32'h11223344);
    chk("p1_odata0", odata0,      0);
    @(negedge clock);
    chk("p1_odata",  odata0,      32'h44332211);
    chk("p1_odata1", odata1,      32'h11223344);
    chk("p1_drop",   out0.tvalid, 0);

    // short packet, then a single-lane packet overlapping the handshake
    put(8'hAA, 0); put(8'hBB, 1);
    chk("p2_tdata",  out0.tdata,  32'h0000BBAA);
    chk("p2_olanes", olanes0,     2);
    chk("p2_tlast",  out0.tlast,  1);
    chk("p2_msb",    out1.tdata,  32'hAABB0000);
    put(8'hCC, 1);
    chk("p3_tvalid", out0.tvalid, 1);
    chk("p3_tdata",  out0.tdata,  32'h000000CC);
    chk("p3_olanes", olanes0,     1);
    chk("p3_odata",  odata0,      32'h0000BBAA);
    chk("p3_msb",    out1.tdata,  32'hCC000000);
    @(negedge clock);
    chk("p3_odata2", odata0,      32'h000000CC);
`ifdef AXIS_UPSIZE_PKT_CNT_EN
    chk("pkt3", pkt0, 3);
`else
    chk("pkt_off", pkt0, 0);
`endif

    // back-pressure
    q.delete();
    out0.tready = 1'b0;
    put(8'h01, 0); put(8'h02, 0); put(8'h03, 0); put(8'h04, 0);
    in0.tdata  = 8'h05;
    in0.tvalid = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_ready", in0.tready,  0);
      chk("bp_data",  out0.tdata,  32'h04030201);
      chk("bp_vld",   out0.tvalid, 1);
      @(negedge clock);
      #1;
    end
    chk("bp_olanes", olanes0, 4);
    out0.tready = 1'b1;
    put(8'h05, 0); put(8'h06, 0); put(8'h07, 0); put(8'h08, 0);
    @(negedge clock);
    @(negedge clock);
    chk("bp_count", q.size(), 2);
    chk("bp_w0", (q.size() > 0) ? q[0] : 32'hDEADDEAD, 32'h04030201);
    chk("bp_w1", (q.size() > 1) ? q[1] : 32'hDEADDEAD, 32'h08070605);
    chk("bp_odata", odata0, 32'h08070605);

    // reset mid-word discards the partial word
    put(8'h01, 0); put(8'h02, 0);
    rst_n = 1'b0;
    #1;
    chk("mr_tvalid", out0.tvalid, 0);
    chk("mr_tdata",  out0.tdata,  0);
    chk("mr_tlast",  out0.tlast,  0);
    chk("mr_olanes", olanes0,     0);
    chk("mr_odata",  odata0,      0);
    chk("mr_pkt",    pkt0,        0);
    @(negedge clock);
    rst_n = 1'b1;
    q.delete();
    put(8'h01, 0); put(8'h02, 0); put(8'h03, 0); put(8'h04, 1);
    chk("mr_word", out0.tdata, 32'h04030201);
    @(negedge clock);
    @(negedge clock);
    chk("mr_count", q.size(), 1);
    chk("mr_w0", (q.size() > 0) ? q[0] : 32'hDEADDEAD, 32'h04030201);

`ifdef AXIS_UPSIZE_PKT_CNT_EN
    chk("pkt_after_rst", pkt0, 1);
    for (int i = 0; i < 65535; i++) put(8'h5A, 1);
    @(negedge clock);
    chk("pkt_wrap", pkt0, 0);
`else
    chk("pkt_off_end", pkt0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
